// File: rtl/mivider_pkg.sv
// mivider_pkg: shared types and default sizing for the sequential fixed-point divider.
// Defaults describe the Q4.6 configuration (10-bit operands, 16-bit raw quotient).
// Modules recompute their own sizes from their parameters; these are the reference values.
package mivider_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_W    = 10;
  localparam int DEF_FRAC = 6;
  localparam int QW       = DEF_W + DEF_FRAC;
  localparam int CNTW     = $clog2(QW + 1);
  localparam logic [DEF_W-1:0] SAT = '1;

endpackage

// File: rtl/mivider_step.sv
// mivider_step: one combinational radix-2 restoring division step.
// Shifts the next dividend bit into the remainder and subtracts the divisor when it fits.
// The incoming remainder is always below the divisor, so the result fits in W+1 bits.
module mivider_step #(
  parameter int W = 10
) (
  input  logic [W:0]   i_rem,
  input  logic         i_bit,
  input  logic [W-1:0] i_div,
  output logic [W:0]   o_rem,
  output logic         o_qbit
);

  logic [W+1:0] w_sh;

  assign w_sh   = {i_rem, i_bit};
  assign o_qbit = (w_sh >= {2'b00, i_div});
  // Modular W+1-bit subtraction is exact here because the true difference is below 2^W.
  assign o_rem  = o_qbit ? (w_sh[W:0] - {1'b0, i_div}) : w_sh[W:0];

endmodule

// File: rtl/mivider.sv
// mivider: unsigned fixed-point divider Q_out = A_in / B_in, one quotient bit per clock.
// Latency 16 cycles from start acceptance to the valid pulse; start is ignored while busy.
// MIVIDER_STATUS_EN adds registered dbz/ovf status outputs updated with Q_out.
module mivider
  import mivider_pkg::*;
#(
  parameter int W    = DEF_W,
  parameter int FRAC = DEF_FRAC
) (
  input  logic         clk,
  input  logic         sclr,
  input  logic [W-1:0] A_in,
  input  logic [W-1:0] B_in,
  input  logic         start,
  output logic [W-1:0] Q_out,
  output logic         busy,
`ifdef MIVIDER_STATUS_EN
  output logic         dbz,
  output logic         ovf,
`endif
  output logic         valid
);

  localparam int L_QW   = W + FRAC;
  localparam int L_CNTW = $clog2(L_QW + 1);
  localparam logic [W-1:0] L_SAT = '1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_accept;
  logic              w_last;
  logic [L_QW-1:0]   r_dvd;
  logic [W-1:0]      r_b;
  logic [W:0]        r_rem;
  logic [L_QW-2:0]   r_quo;
  logic [L_CNTW-1:0] r_cnt;
  logic [W-1:0]      r_q;
  logic              r_valid;
  logic [W:0]        w_rem;
  logic              w_qbit;
  logic [L_QW-1:0]   w_quo;
  logic              w_sat;
`ifdef MIVIDER_STATUS_EN
  logic              r_dbz;
  logic              r_ovf;
`endif

  mivider_step #(.W(W)) u_step (
    .i_rem  (r_rem),
    .i_bit  (r_dvd[L_QW-1]),
    .i_div  (r_b),
    .o_rem  (w_rem),
    .o_qbit (w_qbit)
  );

  // Full quotient including the bit produced on the current step; upper FRAC bits flag overflow.
  assign w_quo = {r_quo, w_qbit};
  assign w_sat = |w_quo[L_QW-1 -: FRAC];

  // Next-state logic: accept start only in IDLE, leave RUN on the final quotient bit.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (r_cnt == L_CNTW'(L_QW - 1)) begin
          w_last      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, datapath and output registers; sclr abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (sclr) begin
      r_state <= IDLE;
      r_dvd   <= '0;
      r_b     <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_cnt   <= '0;
      r_q     <= '0;
      r_valid <= 1'b0;
`ifdef MIVIDER_STATUS_EN
      r_dbz   <= 1'b0;
      r_ovf   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_valid <= 1'b0;
      if (w_accept) begin
        r_dvd <= {A_in, {FRAC{1'b0}}};
        r_b   <= B_in;
        r_rem <= '0;
        r_quo <= '0;
        r_cnt <= '0;
      end else if (r_state == RUN) begin
        r_dvd <= {r_dvd[L_QW-2:0], 1'b0};
        r_rem <= w_rem;
        r_quo <= {r_quo[L_QW-3:0], w_qbit};
        r_cnt <= r_cnt + L_CNTW'(1);
        if (w_last) begin
          r_q     <= w_sat ? L_SAT : w_quo[W-1:0];
          r_valid <= 1'b1;
`ifdef MIVIDER_STATUS_EN
          r_dbz   <= (r_b == '0);
          r_ovf   <= w_sat;
`endif
        end
      end
    end
  end

  assign Q_out = r_q;
  assign busy  = (r_state == RUN);
  assign valid = r_valid;
`ifdef MIVIDER_STATUS_EN
  assign dbz   = r_dbz;
  assign ovf   = r_ovf;
`endif

endmodule

// File: tb/tb_mivider.sv
// tb_mivider: directed checks of the mivider fixed-point divider.
// A vector table covers the arithmetic; hand sequences cover handshake, sclr and back-to-back.
// Outputs are sampled 1 time unit after each rising edge.
module tb_mivider;

  logic       clk;
  logic       sclr;
  logic [9:0] A_in;
  logic [9:0] B_in;
  logic       start;
  logic [9:0] Q_out;
  logic       busy;
  logic       valid;
`ifdef MIVIDER_STATUS_EN
  logic       dbz;
  logic       ovf;
`endif

  int total = 0;
  int bad   = 0;

  mivider dut (
    .clk   (clk),
    .sclr  (sclr),
    .A_in  (A_in),
    .B_in  (B_in),
    .start (start),
    .Q_out (Q_out),
    .busy  (busy),
`ifdef MIVIDER_STATUS_EN
    .dbz   (dbz),
    .ovf   (ovf),
`endif
    .valid (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int q;
    int ovf;
    int dbz;
  } vec_t;

  vec_t vecs[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One isolated operation with a single-cycle start; checks latency, result and pulse width.
  task automatic do_op(input int a, input int b, input int q, input int eo, input int ed,
                       input string nm);
    int lat;
    A_in  = 10'(a);
    B_in  = 10'(b);
    start = 1'b1;
    step();
    start = 1'b0;
    chk({nm, "_busy"}, int'(busy), 1);
    lat = 0;
    for (int k = 1; k <= 24 && lat == 0; k++) begin
      step();
      if (valid) lat = k;
    end
    chk({nm, "_lat"}, lat, 16);
    chk({nm, "_q"}, int'(Q_out), q);
    chk({nm, "_busy_done"}, int'(busy), 0);
`ifdef MIVIDER_STATUS_EN
    chk({nm, "_ovf"}, int'(ovf), eo);
    chk({nm, "_dbz"}, int'(dbz), ed);
`else
    if (eo < 0 || ed < 0) $display("note: negative status expectation ignored");
`endif
    step();
    chk({nm, "_vld_pulse"}, int'(valid), 0);
  endtask

  initial begin
    int n;
    int lat;
    int qv;
    int t[4];
    int qs[4];

    vecs[0] = '{a: 10,   b: 3,    q: 213,  ovf: 0, dbz: 0};
    vecs[1] = '{a: 64,   b: 64,   q: 64,   ovf: 0, dbz: 0};
    vecs[2] = '{a: 1023, b: 1,    q: 1023, ovf: 1, dbz: 0};
    vecs[3] = '{a: 100,  b: 0,    q: 1023, ovf: 1, dbz: 1};
    vecs[4] = '{a: 0,    b: 5,    q: 0,    ovf: 0, dbz: 0};
    vecs[5] = '{a: 64,   b: 32,   q: 128,  ovf: 0, dbz: 0};
    vecs[6] = '{a: 1023, b: 1023, q: 64,   ovf: 0, dbz: 0};
    vecs[7] = '{a: 200,  b: 150,  q: 85,   ovf: 0, dbz: 0};

    sclr  = 1'b1;
    start = 1'b1;
    A_in  = 10'd5;
    B_in  = 10'd1;
    step();
    step();
    chk("rst_q", int'(Q_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(valid), 0);
    start = 1'b0;
    sclr  = 1'b0;
    step();

    // start held for three edges: exactly one operation, 1.0 / 0.5 = 2.0
    A_in  = 10'd64;
    B_in  = 10'd32;
    start = 1'b1;
    step();
    chk("hold3_busy", int'(busy), 1);
    step();
    step();
    start = 1'b0;
    n = 0; lat = 0; qv = -1;
    for (int k = 3; k <= 40; k++) begin
      step();
      if (valid) begin
        n++;
        if (lat == 0) begin lat = k; qv = int'(Q_out); end
      end
    end
    chk("hold3_lat", lat, 16);
    chk("hold3_q", qv, 128);
    chk("hold3_pulses", n, 1);

    for (int i = 0; i < 8; i++)
      do_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].ovf, vecs[i].dbz, $sformatf("vec%0d", i));

    // Operand change and start pulse mid-operation must be ignored
    A_in  = 10'd10;
    B_in  = 10'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    A_in  = 10'd500;
    B_in  = 10'd7;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0; qv = -1;
    for (int k = 0; k < 30; k++) begin
      step();
      if (valid) begin n++; qv = int'(Q_out); end
    end
    chk("midop_pulses", n, 1);
    chk("midop_q", qv, 213);

    // sclr in the middle of RUN abandons the operation
    A_in  = 10'd64;
    B_in  = 10'd32;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (8) step();
    sclr = 1'b1;
    step();
    sclr = 1'b0;
    chk("sclr_busy", int'(busy), 0);
    chk("sclr_valid", int'(valid), 0);
    chk("sclr_q", int'(Q_out), 0);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (valid) n++;
    end
    chk("sclr_no_pulse", n, 0);
    do_op(64, 64, 64, 0, 0, "after_sclr");

    // start held continuously: results 17 cycles apart, each from its own accept-edge operands
    A_in  = 10'd10;
    B_in  = 10'd3;
    start = 1'b1;
    step();
    A_in  = 10'd64;
    B_in  = 10'd64;
    n = 0;
    for (int k = 1; k <= 50; k++) begin
      step();
      if (valid && n < 4) begin
        t[n]  = k;
        qs[n] = int'(Q_out);
        n++;
        if (n == 2) start = 1'b0;
      end
    end
    chk("b2b_count", n, 2);
    if (n >= 2) begin
      chk("b2b_t0", t[0], 16);
      chk("b2b_t1", t[1], 33);
      chk("b2b_q0", qs[0], 213);
      chk("b2b_q1", qs[1], 64);
    end
    chk("b2b_idle", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
